parking_gate_ctrl: RTL and testbench

Parametrised entrance-gate controller for the car-park design: validates a password strobe against a compile-time code, drives the gate LEDs, tracks lot occupancy up to a configurable capacity, and locks the keypad after repeated wrong entries. It generalises the single-slot password gate to N-slot occupancy, configurable code width, entry timeout, retry limiting and a separate departure input. It sits between the gate sensors/keypad and the LED/status outputs.

---
 rtl/parking_pkg.sv | 14 +
 rtl/parking_occ_counter.sv | 26 ++
 rtl/parking_gate_ctrl.sv | 154 +++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the car-park entrance gate controller.
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_PASS  = 3'd1,
        ST_WRONG_PASS = 3'd2,
        ST_GRANTED    = 3'd3,
        ST_LOCKOUT    = 3'd4
    } gate_state_t;

    localparam logic [3:0] DEF_PASS_VAL = 4'b1111;

endpackage

// File: rtl/parking_occ_counter.sv
// Saturating up/down lot occupancy counter; simultaneous up and down cancel out.
module parking_occ_counter #(
    parameter  int CAPACITY = 8,
    localparam int OCC_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] count,
    output logic             full
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + OCC_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - OCC_W'(1);
        end
    end

    assign full = (count == OCC_W'(CAPACITY));

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entrance gate controller: keypad check, gate LEDs, occupancy tracking.
// Define PARKING_LOCKOUT_EN to enable retry limiting and the LOCKOUT state.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | no car being served; red shows lot full to an arriving car
// WAIT_PASS  | car at gate, waiting for a keypad strobe
// WRONG_PASS | last code was wrong, waiting for another try (red on)
// GRANTED    | gate open until the car passes the exit sensor
// LOCKOUT    | keypad ignored for LOCK_CYCLES cycles after too many misses
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter  int              PW_W           = 4,
    parameter  logic [PW_W-1:0] PASS_VAL       = PW_W'(DEF_PASS_VAL),
    parameter  int              CAPACITY       = 8,
    parameter  int              MAX_TRIES      = 3,
    parameter  int              LOCK_CYCLES    = 16,
    parameter  int              TIMEOUT_CYCLES = 32,
    localparam int              OCC_W          = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic             car_depart,
    input  logic [PW_W-1:0]  password,
    input  logic             pass_valid,
    output logic             green_led,
    output logic             red_led,
    output logic             full,
    output logic             locked,
    output logic [OCC_W-1:0] occupancy
);

    // One down-counter serves both the entry timeout and the lockout hold.
    localparam int TMR_MAX = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    gate_state_t      state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             pass_ok;

`ifdef PARKING_LOCKOUT_EN
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TMR_W-1:0] LK_LOAD = TMR_W'(LOCK_CYCLES - 1);

    logic [TRY_W-1:0] tries, tries_nxt, tries_inc;

    always_ff @(posedge clk) begin
        if (rst) tries <= '0;
        else     tries <= tries_nxt;
    end

    assign tries_inc = tries + TRY_W'(1);
`else
    logic unused_max_tries;
    assign unused_max_tries = ^MAX_TRIES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    assign pass_ok = (password == PASS_VAL);

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        green_led = 1'b0;
        red_led   = 1'b0;
        locked    = 1'b0;
`ifdef PARKING_LOCKOUT_EN
        tries_nxt = tries;
`endif
        case (state)
            ST_IDLE: begin
                red_led = full & sensor_entrance;
                if (sensor_entrance && !full) begin
                    state_nxt = ST_WAIT_PASS;
                    tmr_nxt   = TO_LOAD;
`ifdef PARKING_LOCKOUT_EN
                    tries_nxt = '0;
`endif
                end
            end
            ST_WAIT_PASS, ST_WRONG_PASS: begin
                red_led = (state == ST_WRONG_PASS);
                if (pass_valid) begin
                    tmr_nxt = TO_LOAD;
                    if (pass_ok) begin
                        state_nxt = ST_GRANTED;
                    end else begin
                        state_nxt = ST_WRONG_PASS;
`ifdef PARKING_LOCKOUT_EN
                        tries_nxt = tries_inc;
                        if (tries_inc == TRY_W'(MAX_TRIES)) begin
                            state_nxt = ST_LOCKOUT;
                            tmr_nxt   = LK_LOAD;
                        end
`endif
                    end
                end else if (tmr == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_GRANTED: begin
                green_led = 1'b1;
                if (sensor_exit) begin
                    // A second car already at the approach must key in its own code.
                    if (sensor_entrance) begin
                        state_nxt = ST_WAIT_PASS;
                        tmr_nxt   = TO_LOAD;
`ifdef PARKING_LOCKOUT_EN
                        tries_nxt = '0;
`endif
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
`ifdef PARKING_LOCKOUT_EN
            ST_LOCKOUT: begin
                red_led = 1'b1;
                locked  = 1'b1;
                if (tmr == '0) state_nxt = ST_IDLE;
                else           tmr_nxt   = tmr - TMR_W'(1);
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    parking_occ_counter #(
        .CAPACITY (CAPACITY)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state == ST_GRANTED) && sensor_exit),
        .dec   (car_depart),
        .count (occupancy),
        .full  (full)
    );

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Randomized scoreboard bench for parking_gate_ctrl against a behavioural lot/gate model.
module tb_parking_gate_ctrl;
    import parking_pkg::*;

    localparam int PW_W           = 4;
    localparam int CAPACITY       = 8;
    localparam int MAX_TRIES      = 3;
    localparam int LOCK_CYCLES    = 16;
    localparam int TIMEOUT_CYCLES = 32;
    localparam int OCC_W          = $clog2(CAPACITY + 1);
    localparam logic [PW_W-1:0] PASS = 4'b1111;
`ifdef PARKING_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             sensor_entrance, sensor_exit, car_depart, pass_valid;
    logic [PW_W-1:0]  password;
    logic             green_led, red_led, full, locked;
    logic [OCC_W-1:0] occupancy;

    parking_gate_ctrl #(
        .PW_W           (PW_W),
        .PASS_VAL       (PASS),
        .CAPACITY       (CAPACITY),
        .MAX_TRIES      (MAX_TRIES),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sensor_entrance (sensor_entrance),
        .sensor_exit     (sensor_exit),
        .car_depart      (car_depart),
        .password        (password),
        .pass_valid      (pass_valid),
        .green_led       (green_led),
        .red_led         (red_led),
        .full            (full),
        .locked          (locked),
        .occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             green;
        logic             red;
        logic             full;
        logic             locked;
        logic [OCC_W-1:0] occ;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: what the gate is doing, described by flags and counters.
    bit awaiting, wrong_flag, open;
    int lock_left, elapsed, wrong_count, cars;

    task automatic model_reset();
        awaiting    = 1'b0;
        wrong_flag  = 1'b0;
        open        = 1'b0;
        lock_left   = 0;
        elapsed     = 0;
        wrong_count = 0;
        cars        = 0;
    endtask

    task automatic start_wait();
        awaiting    = 1'b1;
        wrong_flag  = 1'b0;
        wrong_count = 0;
        elapsed     = 0;
    endtask

    task automatic step(input logic se, input logic sx, input logic cd, input logic pv,
                        input logic [PW_W-1:0] pw, input logic r);
        exp_t e;
        bit   idle, lot_full, inc;
        @(posedge clk);
        #1;
        sensor_entrance = se;
        sensor_exit     = sx;
        car_depart      = cd;
        pass_valid      = pv;
        password        = pw;
        rst             = r;

        idle     = !awaiting && !open && (lock_left == 0);
        lot_full = (cars == CAPACITY);
        e.green  = open;
        e.locked = (lock_left > 0);
        e.red    = (lock_left > 0) || (awaiting && wrong_flag) || (idle && lot_full && se);
        e.full   = lot_full;
        e.occ    = OCC_W'(cars);
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            inc = open && sx;
            if (inc && !cd && cars < CAPACITY) cars++;
            if (cd && !inc && cars > 0)        cars--;
            if (lock_left > 0) begin
                lock_left--;
            end else if (open) begin
                if (sx) begin
                    open = 1'b0;
                    if (se) start_wait();
                end
            end else if (awaiting) begin
                if (pv) begin
                    elapsed = 0;
                    if (pw == PASS) begin
                        awaiting = 1'b0;
                        open     = 1'b1;
                    end else begin
                        wrong_count++;
                        if (LOCK_EN && wrong_count == MAX_TRIES) begin
                            awaiting  = 1'b0;
                            lock_left = LOCK_CYCLES;
                        end else begin
                            wrong_flag = 1'b1;
                        end
                    end
                end else begin
                    elapsed++;
                    if (elapsed == TIMEOUT_CYCLES) awaiting = 1'b0;
                end
            end else if (se && !lot_full) begin
                start_wait();
            end
        end
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("green_led", 8'(green_led), 8'(mon_e.green));
            check("red_led",   8'(red_led),   8'(mon_e.red));
            check("full",      8'(full),      8'(mon_e.full));
            check("locked",    8'(locked),    8'(mon_e.locked));
            check("occupancy", 8'(occupancy), 8'(mon_e.occ));
        end
    end

    // Percent chances per phase: entrance, exit, depart, strobe, correct code.
    int unsigned ph[5][5] = '{
        '{50, 40, 10, 30, 50},
        '{70, 30,  5, 40,  5},
        '{80, 60,  2, 50, 90},
        '{60, 30, 10,  0,  0},
        '{30, 30, 40, 30, 50}
    };

    logic            s_se, s_sx, s_cd, s_pv, s_r;
    logic [PW_W-1:0] s_pw;

    initial begin
        rst             = 1'b1;
        sensor_entrance = 1'b0;
        sensor_exit     = 1'b0;
        car_depart      = 1'b0;
        pass_valid      = 1'b0;
        password        = '0;
        repeat (3) @(posedge clk);
        model_reset();

        // Correct code admits one car.
        step(1, 0, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 1, PASS,    0);
        step(0, 0, 0, 0, 4'b0000, 0);
        step(0, 1, 0, 0, 4'b0000, 0);
        step(0, 0, 0, 0, 4'b0000, 0);
        // Repeated wrong codes, then strobes while possibly locked out.
        step(1, 0, 0, 0, 4'b0000, 0);
        repeat (3) step(0, 0, 0, 1, 4'b0000, 0);
        repeat (20) step(0, 0, 0, 1, PASS, 0);
        step(0, 1, 1, 0, 4'b0000, 0);
        // Entry with no strobe runs into the timeout.
        step(1, 0, 0, 0, 4'b0000, 0);
        repeat (TIMEOUT_CYCLES + 3) step(0, 0, 0, 0, 4'b0000, 0);
        repeat (3) step(0, 0, 1, 0, 4'b0000, 0);

        for (int rep = 0; rep < 2; rep++) begin
            for (int p = 0; p < 5; p++) begin
                for (int c = 0; c < 600; c++) begin
                    s_se = ($urandom_range(99) < ph[p][0]);
                    s_sx = ($urandom_range(99) < ph[p][1]);
                    s_cd = ($urandom_range(99) < ph[p][2]);
                    s_pv = ($urandom_range(99) < ph[p][3]);
                    if ($urandom_range(99) < ph[p][4]) begin
                        s_pw = PASS;
                    end else begin
                        s_pw = PW_W'($urandom);
                        if (s_pw == PASS) s_pw = s_pw ^ PW_W'(1);
                    end
                    s_r = (p == 0) && ($urandom_range(199) == 0);
                    step(s_se, s_sx, s_cd, s_pv, s_pw, s_r);
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
